// File: rtl/ps2_message_buffer_if.sv
// Bundles the keystroke input, the send handshake and the message outputs
// of the PS/2 message buffer.
//
// Handshake semantics:
//   key_valid  one-cycle strobe; key_ascii is sampled only in a cycle where
//              key_valid is high. Code 0 is never stored.
//   send_req   level request from the user side. The buffer answers by
//              raising data_ready and freezing message_out/count. data_ready
//              stays high until the transmitter pulses tx_done, or until
//              clear aborts the send.
//   tx_done    one-cycle completion pulse from the transmitter. It has an
//              effect only while data_ready is high.
interface ps2_message_buffer_if #(
   parameter int CHAR_W = 8,
   parameter int DEPTH  = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                    key_valid;
   logic [CHAR_W-1:0]       key_ascii;
   logic                    clear;
   logic                    send_req;
   logic                    tx_done;
   logic [DEPTH*CHAR_W-1:0] message_out;
   logic [CW-1:0]           count;
   logic                    data_ready;
   logic                    full;
   logic                    overflow;
   logic                    state_dbg;   // 0 = FILL, 1 = SEND

   modport master (
      output key_valid, key_ascii, clear, send_req, tx_done,
      input  message_out, count, data_ready, full, overflow, state_dbg
   );

   modport slave (
      input  key_valid, key_ascii, clear, send_req, tx_done,
      output message_out, count, data_ready, full, overflow, state_dbg
   );
endinterface

// File: rtl/ps2_message_buffer.sv
// Collects decoded keystrokes into a fixed array of character slots, supports
// backspace, and holds the finished message stable while a transmitter
// drains it. Slot 0 is the first character and sits in the MSBs.
module ps2_message_buffer #(
   parameter int                CHAR_W    = 8,
   parameter int                DEPTH     = 16,
   parameter bit                WRAP_MODE = 1'b0,
   parameter logic [CHAR_W-1:0] DEL_CODE  = CHAR_W'(8'h7F)
) (
   input logic                  clock,
   input logic                  RESETN,
   ps2_message_buffer_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

   state_t            state, nxt_state;
   logic [CHAR_W-1:0] slots     [DEPTH];
   logic [CHAR_W-1:0] nxt_slots [DEPTH];
   logic [CW-1:0]     count_q, nxt_count;
   logic              ready_q, nxt_ready;
   logic              ovf_q, nxt_ovf;
   logic              full_q;
   logic              key_live;
   logic [DEPTH*CHAR_W-1:0] msg_flat;

   // Next-state logic: clear wins, then per-state keystroke and handshake handling.
   always_comb begin
      nxt_slots = slots;
      nxt_count = count_q;
      nxt_state = state;
      nxt_ready = ready_q;
      nxt_ovf   = ovf_q;
      key_live  = bus.key_valid && (bus.key_ascii != '0);

      if (bus.clear) begin
         for (int i = 0; i < DEPTH; i++) nxt_slots[i] = '0;
         nxt_count = '0;
         nxt_state = FILL;
         nxt_ready = 1'b0;
         nxt_ovf   = 1'b0;
      end else if (state == FILL) begin
         if (key_live) begin
            if (bus.key_ascii == DEL_CODE) begin
               if (count_q != '0) begin
                  for (int i = 0; i < DEPTH; i++)
                     if (CW'(i) == count_q - CW'(1)) nxt_slots[i] = '0;
                  nxt_count = count_q - CW'(1);
               end
            end else if (count_q < CW'(DEPTH)) begin
               for (int i = 0; i < DEPTH; i++)
                  if (CW'(i) == count_q) nxt_slots[i] = bus.key_ascii;
               nxt_count = count_q + CW'(1);
            end else if (!WRAP_MODE) begin
               nxt_ovf = 1'b1;
            end else begin
               for (int i = 0; i < DEPTH; i++) nxt_slots[i] = '0;
               nxt_slots[0] = bus.key_ascii;
               nxt_count    = CW'(1);
               nxt_ovf      = 1'b1;
            end
         end
         // The keystroke of this cycle is already folded into nxt_count, so
         // a simultaneous key and send_req ships that key too.
         if (bus.send_req && (nxt_count != '0)) begin
            nxt_state = SEND;
            nxt_ready = 1'b1;
         end
      end else begin
         if (key_live) nxt_ovf = 1'b1;
         if (bus.tx_done) begin
            for (int i = 0; i < DEPTH; i++) nxt_slots[i] = '0;
            nxt_count = '0;
            nxt_state = FILL;
            nxt_ready = 1'b0;
         end
      end
   end

   // State and output registers; reset discards any message in flight.
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         state   <= FILL;
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
         count_q <= '0;
         ready_q <= 1'b0;
         ovf_q   <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         state   <= nxt_state;
         for (int i = 0; i < DEPTH; i++) slots[i] <= nxt_slots[i];
         count_q <= nxt_count;
         ready_q <= nxt_ready;
         ovf_q   <= nxt_ovf;
         full_q  <= (nxt_count == CW'(DEPTH));
      end
   end

   // Pack slots with slot 0 in the most significant character position.
   always_comb begin
      msg_flat = '0;
      for (int i = 0; i < DEPTH; i++)
         msg_flat[(DEPTH-1-i)*CHAR_W +: CHAR_W] = slots[i];
   end

   assign bus.message_out = msg_flat;
   assign bus.count       = count_q;
   assign bus.data_ready  = ready_q;
   assign bus.full        = full_q;
   assign bus.overflow    = ovf_q;
   assign bus.state_dbg   = state;
endmodule

// File: tb/tb_ps2_message_buffer.sv
// Directed bench for ps2_message_buffer. Two instances (drop and wrap modes)
// receive identical stimulus; most checks target the drop-mode instance.
module tb_ps2_message_buffer;
   localparam int CHAR_W = 8;
   localparam int DEPTH  = 16;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int MW     = DEPTH * CHAR_W;

   logic clock;
   logic RESETN;
   int   checks = 0;
   int   fails  = 0;

   ps2_message_buffer_if #(.CHAR_W(CHAR_W), .DEPTH(DEPTH)) b0 ();
   ps2_message_buffer_if #(.CHAR_W(CHAR_W), .DEPTH(DEPTH)) b1 ();

   ps2_message_buffer #(.CHAR_W(CHAR_W), .DEPTH(DEPTH), .WRAP_MODE(1'b0), .DEL_CODE(8'h7F))
      dut0 (.clock(clock), .RESETN(RESETN), .bus(b0.slave));
   ps2_message_buffer #(.CHAR_W(CHAR_W), .DEPTH(DEPTH), .WRAP_MODE(1'b1), .DEL_CODE(8'h7F))
      dut1 (.clock(clock), .RESETN(RESETN), .bus(b1.slave));

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic set_inputs(input logic kv, input logic [7:0] k, input logic clr,
                             input logic sr, input logic td);
      b0.key_valid = kv; b0.key_ascii = k; b0.clear = clr; b0.send_req = sr; b0.tx_done = td;
      b1.key_valid = kv; b1.key_ascii = k; b1.clear = clr; b1.send_req = sr; b1.tx_done = td;
   endtask

   // Apply inputs for one clock edge, then return 1 time unit after it.
   task automatic drive(input logic kv, input logic [7:0] k, input logic clr,
                        input logic sr, input logic td);
      set_inputs(kv, k, clr, sr, td);
      @(posedge clock);
      #1;
      set_inputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic key(input logic [7:0] k);
      drive(1'b1, k, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_clear();
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      set_inputs(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      RESETN = 1'b1;
      #1 RESETN = 1'b0;
      #1;
      checks++; if (b0.count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", b0.count); end
      checks++; if (b0.message_out !== '0) begin fails++; $display("FAIL reset_msg: got %h expected 0", b0.message_out); end
      checks++; if (b0.data_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", b0.data_ready); end
      checks++; if (b0.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", b0.full); end
      checks++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", b0.overflow); end
      checks++; if (b0.state_dbg !== 1'b0) begin fails++; $display("FAIL reset_state: got %b expected 0", b0.state_dbg); end
      @(posedge clock);
      #2 RESETN = 1'b1;
      @(posedge clock);
      #1;
      checks++; if (b0.count !== 5'd0) begin fails++; $display("FAIL post_reset_count: got %0d expected 0", b0.count); end
   endtask

   task automatic test_send();
      logic [MW-1:0] exp_msg;
      exp_msg = {16'h6869, 112'h0};
      do_clear();
      key(8'h68);
      checks++; if (b0.count !== 5'd1) begin fails++; $display("FAIL send_count1: got %0d expected 1", b0.count); end
      key(8'h69);
      checks++; if (b0.data_ready !== 1'b0) begin fails++; $display("FAIL send_ready_early: got %b expected 0", b0.data_ready); end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      checks++; if (b0.count !== 5'd2) begin fails++; $display("FAIL send_count: got %0d expected 2", b0.count); end
      checks++; if (b0.message_out !== exp_msg) begin fails++; $display("FAIL send_msg: got %h expected %h", b0.message_out, exp_msg); end
      checks++; if (b0.data_ready !== 1'b1) begin fails++; $display("FAIL send_ready: got %b expected 1", b0.data_ready); end
      checks++; if (b0.state_dbg !== 1'b1) begin fails++; $display("FAIL send_state: got %b expected 1", b0.state_dbg); end
      checks++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL send_ovf: got %b expected 0", b0.overflow); end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (b0.count !== 5'd0) begin fails++; $display("FAIL txdone_count: got %0d expected 0", b0.count); end
      checks++; if (b0.data_ready !== 1'b0) begin fails++; $display("FAIL txdone_ready: got %b expected 0", b0.data_ready); end
      checks++; if (b0.message_out !== '0) begin fails++; $display("FAIL txdone_msg: got %h expected 0", b0.message_out); end
   endtask

   task automatic test_delete();
      logic [MW-1:0] exp_msg;
      exp_msg = {8'h61, 120'h0};
      do_clear();
      key(8'h61);
      key(8'h62);
      key(8'h7F);
      checks++; if (b0.message_out !== exp_msg) begin fails++; $display("FAIL del_msg1: got %h expected %h", b0.message_out, exp_msg); end
      checks++; if (b0.count !== 5'd1) begin fails++; $display("FAIL del_count1: got %0d expected 1", b0.count); end
      key(8'h7F);
      key(8'h7F);
      checks++; if (b0.count !== 5'd0) begin fails++; $display("FAIL del_count: got %0d expected 0", b0.count); end
      checks++; if (b0.message_out !== '0) begin fails++; $display("FAIL del_msg: got %h expected 0", b0.message_out); end
      checks++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL del_ovf: got %b expected 0", b0.overflow); end
      key(8'h00);
      checks++; if (b0.count !== 5'd0) begin fails++; $display("FAIL zero_key_count: got %0d expected 0", b0.count); end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      checks++; if (b0.state_dbg !== 1'b0) begin fails++; $display("FAIL send_empty_state: got %b expected 0", b0.state_dbg); end
      checks++; if (b0.data_ready !== 1'b0) begin fails++; $display("FAIL send_empty_ready: got %b expected 0", b0.data_ready); end
   endtask

   task automatic test_overflow();
      logic [MW-1:0] exp_all;
      logic [MW-1:0] exp_wrap;
      exp_all  = {16{8'h61}};
      exp_wrap = {8'h61, 120'h0};
      do_clear();
      for (int i = 0; i < 16; i++) key(8'h61);
      checks++; if (b0.full !== 1'b1) begin fails++; $display("FAIL ovf_full16: got %b expected 1", b0.full); end
      checks++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL ovf_flag16: got %b expected 0", b0.overflow); end
      key(8'h61);
      checks++; if (b0.count !== 5'd16) begin fails++; $display("FAIL drop_count: got %0d expected 16", b0.count); end
      checks++; if (b0.full !== 1'b1) begin fails++; $display("FAIL drop_full: got %b expected 1", b0.full); end
      checks++; if (b0.overflow !== 1'b1) begin fails++; $display("FAIL drop_ovf: got %b expected 1", b0.overflow); end
      checks++; if (b0.message_out !== exp_all) begin fails++; $display("FAIL drop_msg: got %h expected %h", b0.message_out, exp_all); end
      checks++; if (b1.count !== 5'd1) begin fails++; $display("FAIL wrap_count: got %0d expected 1", b1.count); end
      checks++; if (b1.message_out !== exp_wrap) begin fails++; $display("FAIL wrap_msg: got %h expected %h", b1.message_out, exp_wrap); end
      checks++; if (b1.overflow !== 1'b1) begin fails++; $display("FAIL wrap_ovf: got %b expected 1", b1.overflow); end
      checks++; if (b1.full !== 1'b0) begin fails++; $display("FAIL wrap_full: got %b expected 0", b1.full); end
      key(8'h7F);
      checks++; if (b0.count !== 5'd15) begin fails++; $display("FAIL full_del_count: got %0d expected 15", b0.count); end
      checks++; if (b0.full !== 1'b0) begin fails++; $display("FAIL full_del_full: got %b expected 0", b0.full); end
      checks++; if (b0.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", b0.overflow); end
      do_clear();
      checks++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL clear_ovf: got %b expected 0", b0.overflow); end
   endtask

   task automatic test_send_hold();
      logic [MW-1:0] exp_msg;
      exp_msg = {8'h78, 120'h0};
      do_clear();
      key(8'h78);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (b0.count !== 5'd1) begin fails++; $display("FAIL fill_txdone_count: got %0d expected 1", b0.count); end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 8'h7A, 1'b0, 1'b1, 1'b0);
      checks++; if (b0.message_out !== exp_msg) begin fails++; $display("FAIL hold_msg: got %h expected %h", b0.message_out, exp_msg); end
      checks++; if (b0.count !== 5'd1) begin fails++; $display("FAIL hold_count: got %0d expected 1", b0.count); end
      checks++; if (b0.overflow !== 1'b1) begin fails++; $display("FAIL hold_ovf: got %b expected 1", b0.overflow); end
      checks++; if (b0.data_ready !== 1'b1) begin fails++; $display("FAIL hold_ready: got %b expected 1", b0.data_ready); end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (b0.count !== 5'd0) begin fails++; $display("FAIL hold_done_count: got %0d expected 0", b0.count); end
      checks++; if (b0.data_ready !== 1'b0) begin fails++; $display("FAIL hold_done_ready: got %b expected 0", b0.data_ready); end
      checks++; if (b0.state_dbg !== 1'b0) begin fails++; $display("FAIL hold_done_state: got %b expected 0", b0.state_dbg); end
      checks++; if (b0.overflow !== 1'b1) begin fails++; $display("FAIL hold_done_ovf: got %b expected 1", b0.overflow); end
   endtask

   task automatic test_same_cycle();
      logic [MW-1:0] exp_msg;
      exp_msg = {8'h71, 120'h0};
      do_clear();
      drive(1'b1, 8'h71, 1'b0, 1'b1, 1'b0);
      checks++; if (b0.state_dbg !== 1'b1) begin fails++; $display("FAIL same_state: got %b expected 1", b0.state_dbg); end
      checks++; if (b0.count !== 5'd1) begin fails++; $display("FAIL same_count: got %0d expected 1", b0.count); end
      checks++; if (b0.message_out !== exp_msg) begin fails++; $display("FAIL same_msg: got %h expected %h", b0.message_out, exp_msg); end
      drive(1'b1, 8'h41, 1'b1, 1'b1, 1'b1);
      checks++; if (b0.data_ready !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b expected 0", b0.data_ready); end
      checks++; if (b0.count !== 5'd0) begin fails++; $display("FAIL abort_count: got %0d expected 0", b0.count); end
      checks++; if (b0.state_dbg !== 1'b0) begin fails++; $display("FAIL abort_state: got %b expected 0", b0.state_dbg); end
      checks++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL abort_ovf: got %b expected 0", b0.overflow); end
   endtask

   task automatic test_async_reset();
      logic [MW-1:0] exp_msg;
      exp_msg = {8'h6D, 120'h0};
      do_clear();
      key(8'h6B);
      drive(1'b1, 8'h6C, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 8'h7A, 1'b0, 1'b0, 1'b0);
      checks++; if (b0.data_ready !== 1'b1) begin fails++; $display("FAIL pre_rst_ready: got %b expected 1", b0.data_ready); end
      #2 RESETN = 1'b0;
      #1;
      checks++; if (b0.count !== 5'd0) begin fails++; $display("FAIL async_count: got %0d expected 0", b0.count); end
      checks++; if (b0.message_out !== '0) begin fails++; $display("FAIL async_msg: got %h expected 0", b0.message_out); end
      checks++; if (b0.data_ready !== 1'b0) begin fails++; $display("FAIL async_ready: got %b expected 0", b0.data_ready); end
      checks++; if (b0.overflow !== 1'b0) begin fails++; $display("FAIL async_ovf: got %b expected 0", b0.overflow); end
      checks++; if (b0.state_dbg !== 1'b0) begin fails++; $display("FAIL async_state: got %b expected 0", b0.state_dbg); end
      #1 RESETN = 1'b1;
      key(8'h6D);
      checks++; if (b0.message_out !== exp_msg) begin fails++; $display("FAIL after_rst_msg: got %h expected %h", b0.message_out, exp_msg); end
      checks++; if (b0.count !== 5'd1) begin fails++; $display("FAIL after_rst_count: got %0d expected 1", b0.count); end
   endtask

   initial begin
      test_reset();
      test_send();
      test_delete();
      test_overflow();
      test_send_hold();
      test_same_cycle();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
